// File: rtl/piso_serializer.sv
// Parallel-in serial-out feeder for the downstream 101 sequence detector.
// Latency: the first bit is on sout the cycle after the accepting edge; a word is WIDTH valid cycles.
// Backpressure: din_ready is high in IDLE or while the last bit is on sout, so words stream with no gap.
//
// Ports:
//   clk        - rising-edge clock
//   arst       - asynchronous active-low reset
//   din        - parallel word, sampled only on the accepting edge
//   din_valid  - din holds a word to transfer
//   din_ready  - combinational, serializer can take din on this edge
//   sout       - registered serial bit (IDLE_BIT when nothing is shifting)
//   sout_valid - sout carries a data bit this cycle
//   word_done  - high while the last bit of a word is on sout
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             word_done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sout_q;
  logic             sout_valid_q;

  logic             last_bit;
  logic             accept;
  logic             load_bit_d;
  logic [WIDTH-1:0] load_rest_d;
  logic             next_bit_d;
  logic [WIDTH-1:0] shift_rest_d;

  // Index of the bit on sout is cnt_q; the last one releases the input side.
  assign last_bit  = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign din_ready = (state_q == IDLE) || last_bit;
  assign accept    = din_valid && din_ready;
  assign word_done = last_bit;

  // The shift register holds the bits not yet driven: the first bit goes
  // straight to sout on load, so the stored copy is already advanced by one.
  always_comb begin
    if (MSB_FIRST) begin
      load_bit_d   = din[WIDTH-1];
      load_rest_d  = din << 1;
      next_bit_d   = shreg_q[WIDTH-1];
      shift_rest_d = shreg_q << 1;
    end else begin
      load_bit_d   = din[0];
      load_rest_d  = din >> 1;
      next_bit_d   = shreg_q[0];
      shift_rest_d = shreg_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      sout_q       <= IDLE_BIT;
      sout_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q      <= SHIFT;
            shreg_q      <= load_rest_d;
            cnt_q        <= '0;
            sout_q       <= load_bit_d;
            sout_valid_q <= 1'b1;
          end
        end
        SHIFT: begin
          if (!last_bit) begin
            shreg_q <= shift_rest_d;
            cnt_q   <= cnt_q + CNT_ONE;
            sout_q  <= next_bit_d;
          end else if (accept) begin
            // Back-to-back word: reload with sout_valid held high, no bubble.
            shreg_q      <= load_rest_d;
            cnt_q        <= '0;
            sout_q       <= load_bit_d;
            sout_valid_q <= 1'b1;
          end else begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            sout_q       <= IDLE_BIT;
            sout_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          sout_q       <= IDLE_BIT;
          sout_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer: WIDTH=8 MSB-first instance and WIDTH=4 LSB-first instance.
// Expected serial bits are queued when a word is accepted by the bench model and popped per cycle.
module tb_piso_serializer;

  typedef struct packed {
    logic b;
    logic d;
  } ent_t;

  logic       clk = 1'b0;
  logic       arst = 1'b0;

  logic [7:0] din_a = 8'h00;
  logic       dv_a = 1'b0;
  logic       rdy_a, sout_a, svld_a, done_a;

  logic [3:0] din_b = 4'h0;
  logic       dv_b = 1'b0;
  logic       rdy_b, sout_b, svld_b, done_b;

  int n_checks = 0;
  int n_errors = 0;

  ent_t qa[$];
  ent_t qb[$];
  ent_t a_cur, b_cur;
  logic a_cur_vld = 1'b0;
  logic b_cur_vld = 1'b0;
  logic a_acc = 1'b0;
  logic b_acc = 1'b0;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_a (
    .clk(clk), .arst(arst), .din(din_a), .din_valid(dv_a), .din_ready(rdy_a),
    .sout(sout_a), .sout_valid(svld_a), .word_done(done_a)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_b (
    .clk(clk), .arst(arst), .din(din_b), .din_valid(dv_b), .din_ready(rdy_b),
    .sout(sout_b), .sout_valid(svld_b), .word_done(done_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out_a(input string tag);
    chk({tag, ".sout"},       {7'd0, sout_a}, {7'd0, a_cur_vld & a_cur.b});
    chk({tag, ".sout_valid"}, {7'd0, svld_a}, {7'd0, a_cur_vld});
    chk({tag, ".word_done"},  {7'd0, done_a}, {7'd0, a_cur_vld & a_cur.d});
    chk({tag, ".din_ready"},  {7'd0, rdy_a},  {7'd0, !a_cur_vld || a_cur.d});
  endtask

  task automatic chk_out_b(input string tag);
    chk({tag, ".sout"},       {7'd0, sout_b}, {7'd0, b_cur_vld & b_cur.b});
    chk({tag, ".sout_valid"}, {7'd0, svld_b}, {7'd0, b_cur_vld});
    chk({tag, ".word_done"},  {7'd0, done_b}, {7'd0, b_cur_vld & b_cur.d});
    chk({tag, ".din_ready"},  {7'd0, rdy_b},  {7'd0, !b_cur_vld || b_cur.d});
  endtask

  // One clock for instance A: model decides acceptance, then outputs are checked 1ns after the edge.
  task automatic step_a(input string tag);
    ent_t e;
    a_acc = 1'b0;
    if (arst && dv_a && (!a_cur_vld || a_cur.d)) begin
      for (int i = 0; i < 8; i++) begin
        e.b = din_a[7-i];
        e.d = (i == 7);
        qa.push_back(e);
      end
      a_acc = 1'b1;
    end
    @(posedge clk);
    #1;
    if (qa.size() > 0) begin
      a_cur = qa.pop_front();
      a_cur_vld = 1'b1;
    end else begin
      a_cur = '0;
      a_cur_vld = 1'b0;
    end
    chk_out_a(tag);
  endtask

  task automatic step_b(input string tag);
    ent_t e;
    b_acc = 1'b0;
    if (arst && dv_b && (!b_cur_vld || b_cur.d)) begin
      for (int i = 0; i < 4; i++) begin
        e.b = din_b[i];
        e.d = (i == 3);
        qb.push_back(e);
      end
      b_acc = 1'b1;
    end
    @(posedge clk);
    #1;
    if (qb.size() > 0) begin
      b_cur = qb.pop_front();
      b_cur_vld = 1'b1;
    end else begin
      b_cur = '0;
      b_cur_vld = 1'b0;
    end
    chk_out_b(tag);
  endtask

  initial begin
    a_cur = '0;
    b_cur = '0;

    // Reset held with a pending full-ones word: nothing may be accepted.
    arst = 1'b0; din_a = 8'hFF; dv_a = 1'b1;
    step_a("rst0");
    step_a("rst1");
    arst = 1'b1; dv_a = 1'b0;
    step_a("post_rst");

    // Single word A5, MSB first.
    din_a = 8'b1010_0101; dv_a = 1'b1;
    step_a("single.acc");
    dv_a = 1'b0; din_a = 8'h00;
    repeat (9) step_a("single");

    // Back-to-back A0 then 05 with din_valid held high.
    din_a = 8'hA0; dv_a = 1'b1;
    step_a("b2b.acc0");
    din_a = 8'h05;
    do step_a("b2b.w0"); while (!a_acc);
    dv_a = 1'b0;
    repeat (9) step_a("b2b.w1");

    // Mid-shift request: FF presented while bit 3 of 00 is on sout.
    din_a = 8'h00; dv_a = 1'b1;
    step_a("mid.acc0");
    dv_a = 1'b0;
    repeat (3) step_a("mid.w0");
    din_a = 8'hFF; dv_a = 1'b1;
    do step_a("mid.wait"); while (!a_acc);
    dv_a = 1'b0;
    repeat (9) step_a("mid.w1");

    // Reset during bit 4 of FF: outputs must clear without waiting for a clock.
    din_a = 8'hFF; dv_a = 1'b1;
    step_a("rmid.acc");
    dv_a = 1'b0;
    repeat (4) step_a("rmid.w0");
    arst = 1'b0;
    #1;
    qa.delete();
    a_cur = '0;
    a_cur_vld = 1'b0;
    chk_out_a("rmid.async");
    step_a("rmid.hold");
    arst = 1'b1;
    din_a = 8'h81; dv_a = 1'b1;
    step_a("rmid.acc81");
    dv_a = 1'b0;
    repeat (9) step_a("rmid.w81");

    // WIDTH=4, LSB first: 0011 then back-to-back 0110.
    step_b("b.idle");
    din_b = 4'b0011; dv_b = 1'b1;
    step_b("b.acc0");
    din_b = 4'b0110;
    do step_b("b.w0"); while (!b_acc);
    dv_b = 1'b0;
    repeat (5) step_b("b.w1");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
